and16: RTL and testbench
========================

Name: and16

Overview:
- 16-bit bitwise AND primitive in the gate library (alongside Not16/Or16/Mux16), used by ALU and datapath blocks.
- Provides a zero-latency combinational result `out` and a registered copy with a valid flag and result flags.
- Downstream logic that needs timing isolation uses the registered copy.

Parameters:
- WIDTH, 16, operand/result bit width. Only 16 is supported and verified; any other value is a configuration error.
- RESET_VAL, 16'h0000, value loaded into out_q on reset.

Ports:
- clk  input  1  single clock; all registers update on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  16  operand A.
- b  input  16  operand B.
- in_valid  input  1  qualifies a/b for the registered path.
- out  output  16  combinational result, a & b.
- out_q  output  16  registered result.
- out_valid  output  1  out_q holds a fresh result.
- zr_q  output  1  registered flag, high when the registered result is 16'h0000.
- ones_q  output  1  registered flag, high when the registered result is 16'hFFFF.

Behaviour:
- Combinational path:
  - out[i] = a[i] & b[i] for i = 0..15.
  - No clock dependency and no X-masking. Any input change propagates within the same delta/time step.
  - out is unaffected by reset.
- Registered path, on a rising clk edge:
  - If reset = 1: out_q = RESET_VAL, out_valid = 0, zr_q = 1, ones_q = 0. Reset has priority over in_valid.
  - Else if in_valid = 1: out_q = a & b, zr_q = (a & b) == 0, ones_q = (a & b) == 16'hFFFF, out_valid = 1.
  - Else: out_q, zr_q and ones_q hold their values; out_valid = 0.
- Latency: out = 0 cycles; out_q, flags and out_valid = 1 cycle.
- Throughput: one result per cycle, no backpressure, no handshake beyond in_valid.
- Reset asserted mid-stream: a result in flight is discarded. out_valid is 0 on the cycle after reset, even if in_valid was high.
- Flags are always consistent with out_q. zr_q and ones_q are never both 1.

Optional Feature:
- Macro: AND16_POPCNT_EN.
- When defined:
  - Adds output port `popcnt_q` (input side: none; output, width 5), the registered count of 1-bits in a & b, range 0..16.
  - It updates under the same conditions as out_q.
  - It resets to 0. This is a defined exception: with RESET_VAL != 0, popcnt_q still resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package and16_pkg holds:
  - WIDTH_C = 16.
  - ALL_ONES_C = 16'hFFFF.
  - ZERO_C = 16'h0000.
  - typedef word_t (logic [15:0]).
  - typedef cnt_t (logic [4:0]).
- One natural sub-module: and16_popcnt, a combinational 16-bit population count. It is instantiated only under AND16_POPCNT_EN.

Test Plan:
- a=0000, b=0000 -> out=0000 immediately; after an in_valid clock, out_q=0000, zr_q=1, ones_q=0, popcnt_q=0.
- a=0000, b=FFFF, then a=FFFF, b=FFFF -> out=0000 then FFFF. The registered step gives out_q=FFFF, ones_q=1, zr_q=0, popcnt_q=16.
- a=AAAA, b=5555 -> out=0000, zr_q=1. Then a=3CC3, b=0FF0 -> out=0CC0, popcnt_q=4, zr_q=0.
- a=1234, b=9876 -> out=1034 combinationally; next edge out_q=1034, out_valid=1, popcnt_q=4.
- in_valid high with reset asserted on the same edge -> out_q=0000, out_valid=0, zr_q=1; out still tracks a & b.
- in_valid low for 3 cycles after a valid result -> out_q and flags held, out_valid=0 each cycle.

Source files
------------

// File: rtl/and16_pkg.sv
// and16_pkg: shared widths, constants and types for the and16 gate
package and16_pkg;
  localparam int WIDTH_C = 16;
  typedef logic [15:0] word_t;
  typedef logic [4:0] cnt_t;
  localparam word_t ALL_ONES_C = 16'hFFFF;
  localparam word_t ZERO_C = 16'h0000;
endpackage

// File: rtl/and16_popcnt.sv
// and16_popcnt: combinational 16-bit population count
module and16_popcnt
  import and16_pkg::*;
(
  input  word_t w,
  output cnt_t  cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH_C; i++) cnt = cnt + cnt_t'(w[i]);
  end
endmodule

// File: rtl/and16.sv
// and16: 16-bit AND with combinational out and registered out_q/flags; AND16_POPCNT_EN adds registered popcnt_q
module and16
  import and16_pkg::*;
#(
  parameter int    WIDTH     = WIDTH_C,
  parameter word_t RESET_VAL = ZERO_C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             zr_q,
  output logic             ones_q
`ifdef AND16_POPCNT_EN
  ,output logic [4:0]      popcnt_q
`endif
);
  assign out = a & b;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= RESET_VAL;
      out_valid <= 1'b0;
      zr_q      <= 1'b1;
      ones_q    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q  <= out;
        zr_q   <= out == ZERO_C;
        ones_q <= out == ALL_ONES_C;
      end
    end
  end
`ifdef AND16_POPCNT_EN
  cnt_t cnt;
  and16_popcnt u_popcnt (.w(out), .cnt(cnt));
  always_ff @(posedge clk) begin
    if (reset) popcnt_q <= '0;
    else if (in_valid) popcnt_q <= cnt;
  end
`endif
endmodule

// File: tb/tb_and16.sv
// tb_and16: table-driven self-checking bench for and16
module tb_and16;
  logic        clk = 1'b0;
  logic        reset, in_valid;
  logic [15:0] a, b, out, out_q;
  logic        out_valid, zr_q, ones_q;
  logic [4:0]  popcnt_q;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] e_out;
    logic [15:0] e_q;
    logic        e_v;
    logic        e_zr;
    logic        e_ones;
    logic [4:0]  e_pc;
  } vec_t;

  vec_t vec [13];

  and16 dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
    .out(out), .out_q(out_q), .out_valid(out_valid), .zr_q(zr_q), .ones_q(ones_q)
`ifdef AND16_POPCNT_EN
    , .popcnt_q(popcnt_q)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec[0]  = '{1'b1, 1'b1, 16'h1234, 16'h9876, 16'h1034, 16'h0000, 1'b0, 1'b1, 1'b0, 5'd0};
    vec[1]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 5'd0};
    vec[2]  = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 5'd0};
    vec[3]  = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 5'd16};
    vec[4]  = '{1'b0, 1'b1, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 5'd0};
    vec[5]  = '{1'b0, 1'b1, 16'h3CC3, 16'h0FF0, 16'h0CC0, 16'h0CC0, 1'b1, 1'b0, 1'b0, 5'd4};
    vec[6]  = '{1'b0, 1'b1, 16'h1234, 16'h9876, 16'h1034, 16'h1034, 1'b1, 1'b0, 1'b0, 5'd4};
    vec[7]  = '{1'b0, 1'b0, 16'hFFFF, 16'h00FF, 16'h00FF, 16'h1034, 1'b0, 1'b0, 1'b0, 5'd4};
    vec[8]  = '{1'b0, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 16'h1034, 1'b0, 1'b0, 1'b0, 5'd4};
    vec[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h1034, 1'b0, 1'b0, 1'b0, 5'd4};
    vec[10] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 5'd0};
    vec[11] = '{1'b0, 1'b1, 16'h8001, 16'hC003, 16'h8001, 16'h8001, 1'b1, 1'b0, 1'b0, 5'd2};
    vec[12] = '{1'b0, 1'b1, 16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0, 1'b0, 5'd15};
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    #1;
    for (int i = 0; i < 13; i++) begin
      reset = vec[i].rst; in_valid = vec[i].iv; a = vec[i].a; b = vec[i].b;
      #1 chk("out", i, out, vec[i].e_out);
      @(posedge clk);
      #1;
      chk("out_q", i, out_q, vec[i].e_q);
      chk("out_valid", i, 16'(out_valid), 16'(vec[i].e_v));
      chk("zr_q", i, 16'(zr_q), 16'(vec[i].e_zr));
      chk("ones_q", i, 16'(ones_q), 16'(vec[i].e_ones));
`ifdef AND16_POPCNT_EN
      chk("popcnt_q", i, 16'(popcnt_q), 16'(vec[i].e_pc));
`endif
    end
    reset = 1'b1; in_valid = 1'b1; a = 16'h00F0; b = 16'h0FF0;
    #1 chk("out_in_reset", 100, out, 16'h00F0);
    b = 16'h0030;
    #1 chk("out_no_clock", 101, out, 16'h0030);
    chk("out_q_no_clock", 101, out_q, 16'hFFFE);
    @(posedge clk);
    #1 chk("out_q_after_rst", 102, out_q, 16'h0000);
    chk("zr_after_rst", 102, 16'(zr_q), 16'h0001);
    a = 16'h5A5A;
    #1 chk("out_tracks_rst", 103, out, 16'h0010);
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("hold_q", 200 + i, out_q, 16'h0000);
      chk("hold_valid", 200 + i, 16'(out_valid), 16'h0000);
      chk("hold_zr", 200 + i, 16'(zr_q), 16'h0001);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
